// File: rtl/conv2_fmap_mem_read.sv
// Address generator for the conv1 output feature-map RAM feeding the conv2 MAC.
// It walks a KxK window over two channel halves in parallel and emits tap markers aligned to the RAM read data.
module conv2_fmap_mem_read #(
  parameter int FMAP_W   = 12,
  parameter int K        = 5,
  parameter int CH_HALF  = 3,
  parameter int RAM_LAT  = 1,
  parameter int ADDR_W   = 10,
  parameter int HALF_OFF = 432
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              enable,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic              tap_valid,
  output logic              tap_first,
  output logic              tap_last,
  output logic [2:0]        out_row,
  output logic [2:0]        out_col,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] K_MAX   = 3'(K - 1);
  localparam logic [1:0] CH_MAX  = 2'(CH_HALF - 1);
  localparam logic [2:0] OUT_MAX = 3'(FMAP_W - K);

  localparam logic [ADDR_W-1:0] CH_STRIDE  = ADDR_W'(FMAP_W * FMAP_W);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(FMAP_W);
  localparam logic [ADDR_W-1:0] HALF_BASE  = ADDR_W'(HALF_OFF);

  logic [1:0]        state_q, state_d;
  logic [2:0]        kc_q, kc_d, kr_q, kr_d, ocol_q, ocol_d, orow_q, orow_d;
  logic [1:0]        ch_q, ch_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;

  logic issue, first_flag, last_flag, final_tap;

  // Marker pipeline: stage 0 holds issue-time values, stage RAM_LAT-1 lines up with RAM data.
  logic [RAM_LAT-1:0] vld_q, fst_q, lst_q;
  logic [2:0]         row_q [RAM_LAT];
  logic [2:0]         col_q [RAM_LAT];

  assign issue      = (state_q == S_RUN) && enable;
  assign first_flag = issue && (kc_q == 3'd0) && (kr_q == 3'd0) && (ch_q == 2'd0);
  assign last_flag  = issue && (kc_q == K_MAX) && (kr_q == K_MAX) && (ch_q == CH_MAX);
  assign final_tap  = last_flag && (ocol_q == OUT_MAX) && (orow_q == OUT_MAX);

  always_comb begin
    state_d = state_q;
    kc_d    = kc_q;
    kr_d    = kr_q;
    ch_d    = ch_q;
    ocol_d  = ocol_q;
    orow_d  = orow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          kc_d    = '0;
          kr_d    = '0;
          ch_d    = '0;
          ocol_d  = '0;
          orow_d  = '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          // kc innermost, then kr, ch, ocol, orow; the final tap wraps everything to 0.
          if (kc_q == K_MAX) begin
            kc_d = '0;
            if (kr_q == K_MAX) begin
              kr_d = '0;
              if (ch_q == CH_MAX) begin
                ch_d = '0;
                if (ocol_q == OUT_MAX) begin
                  ocol_d = '0;
                  orow_d = (orow_q == OUT_MAX) ? 3'd0 : orow_q + 3'd1;
                end else begin
                  ocol_d = ocol_q + 3'd1;
                end
              end else begin
                ch_d = ch_q + 2'd1;
              end
            end else begin
              kr_d = kr_q + 3'd1;
            end
          end else begin
            kc_d = kc_q + 3'd1;
          end
          if (final_tap) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          kc_d    = '0;
          kr_d    = '0;
          ch_d    = '0;
          ocol_d  = '0;
          orow_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Address always tracks the next counter value, so the registered address presents the current tap.
    addr0_d = ADDR_W'(ch_d) * CH_STRIDE
            + (ADDR_W'(orow_d) + ADDR_W'(kr_d)) * ROW_STRIDE
            + ADDR_W'(ocol_d) + ADDR_W'(kc_d);
    addr1_d = addr0_d + HALF_BASE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      kc_q    <= '0;
      kr_q    <= '0;
      ch_q    <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      addr0_q <= '0;
      addr1_q <= HALF_BASE;
    end else begin
      state_q <= state_d;
      kc_q    <= kc_d;
      kr_q    <= kr_d;
      ch_q    <= ch_d;
      ocol_q  <= ocol_d;
      orow_q  <= orow_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      fst_q <= '0;
      lst_q <= '0;
      for (int i = 0; i < RAM_LAT; i++) begin
        row_q[i] <= '0;
        col_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= issue;
      fst_q[0] <= first_flag;
      lst_q[0] <= last_flag;
      row_q[0] <= orow_q;
      col_q[0] <= ocol_q;
      for (int i = 1; i < RAM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        fst_q[i] <= fst_q[i-1];
        lst_q[i] <= lst_q[i-1];
        row_q[i] <= row_q[i-1];
        col_q[i] <= col_q[i-1];
      end
    end
  end

  assign addr0     = addr0_q;
  assign addr1     = addr1_q;
  assign tap_valid = vld_q[RAM_LAT-1];
  assign tap_first = fst_q[RAM_LAT-1];
  assign tap_last  = lst_q[RAM_LAT-1];
  assign out_row   = row_q[RAM_LAT-1];
  assign out_col   = col_q[RAM_LAT-1];
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign state_o   = state_q;

endmodule
